ysyx_23060042_ifu_fetch: RTL and testbench

//   Instruction fetch unit: owns the PC and issues one word-aligned read at a time to instruction memory.

---
 rtl/ysyx_23060042_pkg.sv | 13 +
 rtl/ysyx_23060042_ifu_fetch.sv | 134 +++++++++++++
 tb/tb_ysyx_23060042_ifu_fetch.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060042_pkg.sv
// Shared types and constants for the ysyx_23060042 fetch front end.
package ysyx_23060042_pkg;

   typedef enum logic [1:0] {
      FETCH_REQ  = 2'd0,
      FETCH_WAIT = 2'd1,
      FETCH_HOLD = 2'd2
   } fetch_state_t;

   localparam logic [31:0] RESET_PC = 32'h8000_0000;
   localparam logic [31:0] INST_NOP = 32'h0000_0013;

endpackage

// File: rtl/ysyx_23060042_ifu_fetch.sv
// Instruction fetch unit: owns the PC, keeps at most one imem read in flight,
// buffers the returned word and hands it to the IDU over valid/ready.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// FETCH_REQ  | read request for pc presented to imem, waiting for acceptance
// FETCH_WAIT | request accepted, waiting for the single response
// FETCH_HOLD | instruction buffered, inst_valid high until the IDU takes it
//
// kill marks the in-flight response as stale after a redirect; that word is
// dropped and the fetch restarts at the redirect target.
module ysyx_23060042_ifu_fetch
   import ysyx_23060042_pkg::*;
#(
   parameter logic [31:0] RESET_PC = ysyx_23060042_pkg::RESET_PC,
   parameter int          XLEN     = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [XLEN-1:0] inst,
   output logic [XLEN-1:0] inst_pc,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            fetch_busy
);

   fetch_state_t    state, state_n;
   logic [XLEN-1:0] pc, pc_n;
   logic            kill, kill_n;
   logic            inst_valid_q, inst_valid_n;
   logic [XLEN-1:0] inst_q, inst_n;
   logic [XLEN-1:0] inst_pc_q, inst_pc_n;
   logic [XLEN-1:0] target;

   // redirect targets are always word aligned; the low two bits are dropped
   assign target = redirect_pc & ~XLEN'(3);

   // state, PC, kill flag and instruction buffer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= FETCH_REQ;
         pc           <= RESET_PC;
         kill         <= 1'b0;
         inst_valid_q <= 1'b0;
         inst_q       <= INST_NOP;
         inst_pc_q    <= RESET_PC;
      end else begin
         state        <= state_n;
         pc           <= pc_n;
         kill         <= kill_n;
         inst_valid_q <= inst_valid_n;
         inst_q       <= inst_n;
         inst_pc_q    <= inst_pc_n;
      end
   end

   // next-state logic; a redirect takes priority over every other event
   always_comb begin
      state_n      = state;
      pc_n         = pc;
      kill_n       = kill;
      inst_valid_n = inst_valid_q;
      inst_n       = inst_q;
      inst_pc_n    = inst_pc_q;
      case (state)
         FETCH_REQ: begin
            if (redirect_valid) begin
               pc_n = target;
               if (imem_req_ready) begin
                  // the old address was accepted anyway; its word must be dropped
                  kill_n  = 1'b1;
                  state_n = FETCH_WAIT;
               end
            end else if (imem_req_ready) begin
               state_n = FETCH_WAIT;
            end
         end
         FETCH_WAIT: begin
            if (redirect_valid) begin
               pc_n = target;
               if (imem_rsp_valid) begin
                  kill_n  = 1'b0;
                  state_n = FETCH_REQ;
               end else begin
                  kill_n = 1'b1;
               end
            end else if (imem_rsp_valid) begin
               if (kill) begin
                  kill_n  = 1'b0;
                  state_n = FETCH_REQ;
               end else begin
                  inst_n       = imem_rsp_data;
                  inst_pc_n    = pc;
                  inst_valid_n = 1'b1;
                  state_n      = FETCH_HOLD;
               end
            end
         end
         FETCH_HOLD: begin
            if (redirect_valid) begin
               // a same-cycle handshake still completes, but the target wins over pc+4
               pc_n         = target;
               inst_valid_n = 1'b0;
               state_n      = FETCH_REQ;
            end else if (inst_ready) begin
               pc_n         = pc + XLEN'(4);
               inst_valid_n = 1'b0;
               state_n      = FETCH_REQ;
            end
         end
         default: begin
            state_n      = FETCH_REQ;
            kill_n       = 1'b0;
            inst_valid_n = 1'b0;
         end
      endcase
   end

   // request is held off while reset is asserted so nothing leaks out during reset
   assign imem_req_valid = rst_n && (state == FETCH_REQ);
   assign imem_req_addr  = pc;
   assign inst_valid     = inst_valid_q;
   assign inst           = inst_q;
   assign inst_pc        = inst_pc_q;
   assign fetch_busy     = (state == FETCH_WAIT);

endmodule

// File: tb/tb_ysyx_23060042_ifu_fetch.sv
// Directed bench for the fetch unit. The bench acts on the falling edge: it
// samples outputs, drives inputs, and a small imem model answers each accepted
// request mem_k cycles after the first WAIT cycle (mem_k=0 answers in the
// first WAIT cycle). A second instance checks PC wrap at the top of memory.
module tb_ysyx_23060042_ifu_fetch;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
   logic [31:0] imem_req_addr, imem_rsp_data;
   logic        inst_valid, inst_ready, redirect_valid, fetch_busy;
   logic [31:0] inst, inst_pc, redirect_pc;

   logic        b_req_valid, b_req_ready, b_rsp_valid;
   logic [31:0] b_req_addr, b_rsp_data;
   logic        b_inst_valid, b_inst_ready, b_redirect_valid, b_busy;
   logic [31:0] b_inst, b_inst_pc, b_redirect_pc;

   ysyx_23060042_ifu_fetch dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .fetch_busy(fetch_busy)
   );

   ysyx_23060042_ifu_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_top (
      .clk(clk), .rst_n(rst_n),
      .imem_req_valid(b_req_valid), .imem_req_ready(b_req_ready), .imem_req_addr(b_req_addr),
      .imem_rsp_valid(b_rsp_valid), .imem_rsp_data(b_rsp_data),
      .inst_valid(b_inst_valid), .inst_ready(b_inst_ready), .inst(b_inst), .inst_pc(b_inst_pc),
      .redirect_valid(b_redirect_valid), .redirect_pc(b_redirect_pc), .fetch_busy(b_busy)
   );

   int          checks = 0;
   int          failures = 0;
   logic        mem_ready_cfg;
   int          mem_k;
   logic        pend;
   int          cnt;
   logic [31:0] paddr;
   logic        stray_ok;
   logic [31:0] acc_log[$];

   // memory content: halves of the address swapped
   function automatic logic [31:0] memf(input logic [31:0] a);
      return {a[15:0], a[31:16]};
   endfunction

   task automatic mem_rsp();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'hDEAD_BEEF;
      if (pend) begin
         if (cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memf(paddr);
            pend = 1'b0;
         end else begin
            cnt--;
         end
      end
      imem_req_ready = mem_ready_cfg;
      if (imem_rsp_valid) begin
         checks++;
         if (!fetch_busy && !stray_ok) begin
            failures++;
            $display("FAIL rsp_outside_wait busy=%b required=1", fetch_busy);
         end
      end
   endtask

   task automatic cyc();
      if (imem_req_valid && imem_req_ready) begin
         acc_log.push_back(imem_req_addr);
         pend  = 1'b1;
         cnt   = mem_k;
         paddr = imem_req_addr;
      end
      @(posedge clk);
      @(negedge clk);
      mem_rsp();
   endtask

   task automatic test_reset();
      repeat (2) cyc();
      checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL rst_req_valid got=%b exp=0", imem_req_valid); end
      checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rst_inst_valid got=%b exp=0", inst_valid); end
      checks++; if (inst !== 32'h0000_0013) begin failures++; $display("FAIL rst_inst got=%h exp=00000013", inst); end
      checks++; if (inst_pc !== 32'h8000_0000) begin failures++; $display("FAIL rst_inst_pc got=%h exp=80000000", inst_pc); end
      checks++; if (fetch_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", fetch_busy); end
      checks++; if (b_req_valid !== 1'b0) begin failures++; $display("FAIL rst_b_req_valid got=%b exp=0", b_req_valid); end
      rst_n = 1'b1;
      #1;
      checks++; if (imem_req_valid !== 1'b1) begin failures++; $display("FAIL rel_req_valid got=%b exp=1", imem_req_valid); end
      checks++; if (imem_req_addr !== 32'h8000_0000) begin failures++; $display("FAIL rel_req_addr got=%h exp=80000000", imem_req_addr); end
   endtask

   task automatic test_stream();
      logic [31:0] hs_pc[3];
      logic [31:0] hs_inst[3];
      int          hs_cyc[3];
      int          hs_n;
      hs_n = 0;
      acc_log.delete();
      mem_k = 0; mem_ready_cfg = 1'b1; imem_req_ready = 1'b1; inst_ready = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         cyc();
         if (inst_valid && inst_ready) begin
            if (hs_n < 3) begin
               hs_pc[hs_n] = inst_pc; hs_inst[hs_n] = inst; hs_cyc[hs_n] = i;
            end
            hs_n++;
         end
      end
      mem_ready_cfg = 1'b0; imem_req_ready = 1'b0; inst_ready = 1'b0;
      checks++; if (hs_n !== 3) begin failures++; $display("FAIL stream_count got=%0d exp=3", hs_n); end
      checks++; if (acc_log.size() !== 3) begin failures++; $display("FAIL stream_reqs got=%0d exp=3", acc_log.size()); end
      if (acc_log.size() == 3) begin
         checks++; if (acc_log[0] !== 32'h8000_0000) begin failures++; $display("FAIL stream_addr0 got=%h exp=80000000", acc_log[0]); end
         checks++; if (acc_log[1] !== 32'h8000_0004) begin failures++; $display("FAIL stream_addr1 got=%h exp=80000004", acc_log[1]); end
         checks++; if (acc_log[2] !== 32'h8000_0008) begin failures++; $display("FAIL stream_addr2 got=%h exp=80000008", acc_log[2]); end
      end
      if (hs_n >= 3) begin
         checks++; if (hs_pc[0] !== 32'h8000_0000) begin failures++; $display("FAIL stream_pc0 got=%h exp=80000000", hs_pc[0]); end
         checks++; if (hs_pc[2] !== 32'h8000_0008) begin failures++; $display("FAIL stream_pc2 got=%h exp=80000008", hs_pc[2]); end
         checks++; if (hs_inst[1] !== 32'h0004_8000) begin failures++; $display("FAIL stream_inst1 got=%h exp=00048000", hs_inst[1]); end
         checks++; if (hs_cyc[0] !== 2) begin failures++; $display("FAIL stream_first_cycle got=%0d exp=2", hs_cyc[0]); end
         checks++; if (hs_cyc[1] - hs_cyc[0] !== 3) begin failures++; $display("FAIL stream_gap01 got=%0d exp=3", hs_cyc[1] - hs_cyc[0]); end
         checks++; if (hs_cyc[2] - hs_cyc[1] !== 3) begin failures++; $display("FAIL stream_gap12 got=%0d exp=3", hs_cyc[2] - hs_cyc[1]); end
      end
   endtask

   task automatic test_hold();
      int   n;
      logic stable;
      acc_log.delete();
      mem_k = 3; mem_ready_cfg = 1'b1; imem_req_ready = 1'b1; inst_ready = 1'b0;
      n = 0;
      do begin
         cyc();
         n++;
      end while (!inst_valid && n < 20);
      checks++; if (n !== 5) begin failures++; $display("FAIL hold_latency got=%0d exp=5", n); end
      stable = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (inst !== 32'h000C_8000 || inst_pc !== 32'h8000_000C || !inst_valid || imem_req_valid) stable = 1'b0;
         cyc();
      end
      checks++; if (stable !== 1'b1) begin failures++; $display("FAIL hold_stable got=%b exp=1", stable); end
      checks++; if (acc_log.size() !== 1) begin failures++; $display("FAIL hold_reqs got=%0d exp=1", acc_log.size()); end
      inst_ready = 1'b1;
      cyc();
      inst_ready = 1'b0;
      checks++; if (imem_req_addr !== 32'h8000_0010) begin failures++; $display("FAIL hold_next_addr got=%h exp=80000010", imem_req_addr); end
      checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL hold_release got=%b exp=0", inst_valid); end
      mem_ready_cfg = 1'b0; imem_req_ready = 1'b0;
   endtask

   task automatic test_redirect_wait();
      logic saw;
      mem_k = 2; mem_ready_cfg = 1'b1; imem_req_ready = 1'b1;
      cyc();
      redirect_valid = 1'b1; redirect_pc = 32'h8000_0103;
      mem_ready_cfg = 1'b0; imem_req_ready = 1'b0;
      cyc();
      redirect_valid = 1'b0;
      checks++; if (fetch_busy !== 1'b1) begin failures++; $display("FAIL rdw_busy got=%b exp=1", fetch_busy); end
      saw = inst_valid;
      cyc();
      saw = saw | inst_valid;
      cyc();
      saw = saw | inst_valid;
      checks++; if (saw !== 1'b0) begin failures++; $display("FAIL rdw_dropped_valid got=%b exp=0", saw); end
      checks++; if (imem_req_valid !== 1'b1) begin failures++; $display("FAIL rdw_req_valid got=%b exp=1", imem_req_valid); end
      checks++; if (imem_req_addr !== 32'h8000_0100) begin failures++; $display("FAIL rdw_addr got=%h exp=80000100", imem_req_addr); end
      checks++; if (inst !== 32'h000C_8000) begin failures++; $display("FAIL rdw_inst_kept got=%h exp=000c8000", inst); end
   endtask

   task automatic test_redirect_rsp();
      mem_k = 0; mem_ready_cfg = 1'b1; imem_req_ready = 1'b1;
      cyc();
      checks++; if (fetch_busy !== 1'b1) begin failures++; $display("FAIL rdr_busy got=%b exp=1", fetch_busy); end
      redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
      mem_ready_cfg = 1'b0; imem_req_ready = 1'b0;
      cyc();
      redirect_valid = 1'b0;
      checks++; if (imem_req_valid !== 1'b1) begin failures++; $display("FAIL rdr_req_valid got=%b exp=1", imem_req_valid); end
      checks++; if (imem_req_addr !== 32'h8000_0200) begin failures++; $display("FAIL rdr_addr got=%h exp=80000200", imem_req_addr); end
      checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rdr_inst_valid got=%b exp=0", inst_valid); end
      mem_ready_cfg = 1'b1; imem_req_ready = 1'b1;
      cyc();
      mem_ready_cfg = 1'b0; imem_req_ready = 1'b0;
      cyc();
      checks++; if (inst_valid !== 1'b1) begin failures++; $display("FAIL rdr_refetch_valid got=%b exp=1", inst_valid); end
      checks++; if (inst_pc !== 32'h8000_0200) begin failures++; $display("FAIL rdr_refetch_pc got=%h exp=80000200", inst_pc); end
      checks++; if (inst !== 32'h0200_8000) begin failures++; $display("FAIL rdr_refetch_inst got=%h exp=02008000", inst); end
   endtask

   task automatic test_redirect_hold();
      int hs;
      hs = 0;
      inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_0400;
      if (inst_valid && inst_ready) hs++;
      cyc();
      redirect_valid = 1'b0;
      if (inst_valid && inst_ready) hs++;
      checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rdh_inst_valid got=%b exp=0", inst_valid); end
      checks++; if (imem_req_addr !== 32'h8000_0400) begin failures++; $display("FAIL rdh_addr got=%h exp=80000400", imem_req_addr); end
      mem_ready_cfg = 1'b1; imem_req_ready = 1'b1;
      cyc();
      if (inst_valid && inst_ready) hs++;
      mem_ready_cfg = 1'b0; imem_req_ready = 1'b0;
      cyc();
      if (inst_valid && inst_ready) hs++;
      checks++; if (inst_pc !== 32'h8000_0400) begin failures++; $display("FAIL rdh_inst_pc got=%h exp=80000400", inst_pc); end
      cyc();
      inst_ready = 1'b0;
      checks++; if (hs !== 2) begin failures++; $display("FAIL rdh_handshakes got=%0d exp=2", hs); end
      checks++; if (imem_req_addr !== 32'h8000_0404) begin failures++; $display("FAIL rdh_next_addr got=%h exp=80000404", imem_req_addr); end
   endtask

   task automatic test_wrap_reset();
      checks++; if (b_req_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_first_addr got=%h exp=fffffffc", b_req_addr); end
      b_req_ready = 1'b1;
      cyc();
      b_req_ready = 1'b0; b_rsp_valid = 1'b1; b_rsp_data = 32'h1234_5678;
      cyc();
      b_rsp_valid = 1'b0;
      checks++; if (b_inst_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_inst_pc got=%h exp=fffffffc", b_inst_pc); end
      checks++; if (b_inst !== 32'h1234_5678) begin failures++; $display("FAIL wrap_inst got=%h exp=12345678", b_inst); end
      b_inst_ready = 1'b1;
      cyc();
      b_inst_ready = 1'b0;
      checks++; if (b_req_valid !== 1'b1) begin failures++; $display("FAIL wrap_req_valid got=%b exp=1", b_req_valid); end
      checks++; if (b_req_addr !== 32'h0000_0000) begin failures++; $display("FAIL wrap_second_addr got=%h exp=00000000", b_req_addr); end

      mem_k = 3; mem_ready_cfg = 1'b1; imem_req_ready = 1'b1;
      cyc();
      mem_ready_cfg = 1'b0; imem_req_ready = 1'b0;
      checks++; if (fetch_busy !== 1'b1) begin failures++; $display("FAIL arst_pre_busy got=%b exp=1", fetch_busy); end
      stray_ok = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      checks++; if (fetch_busy !== 1'b0) begin failures++; $display("FAIL arst_busy got=%b exp=0", fetch_busy); end
      checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL arst_req_valid got=%b exp=0", imem_req_valid); end
      checks++; if (imem_req_addr !== 32'h8000_0000) begin failures++; $display("FAIL arst_pc got=%h exp=80000000", imem_req_addr); end
      cyc();
      rst_n = 1'b1;
      cyc();
      cyc();
      cyc();
      checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL arst_late_rsp got=%b exp=0", inst_valid); end
      checks++; if (imem_req_valid !== 1'b1) begin failures++; $display("FAIL arst_req_after got=%b exp=1", imem_req_valid); end
      checks++; if (imem_req_addr !== 32'h8000_0000) begin failures++; $display("FAIL arst_addr got=%h exp=80000000", imem_req_addr); end
      checks++; if (fetch_busy !== 1'b0) begin failures++; $display("FAIL arst_busy_after got=%b exp=0", fetch_busy); end
      stray_ok = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
      inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
      b_req_ready = 1'b0; b_rsp_valid = 1'b0; b_rsp_data = 32'h0;
      b_inst_ready = 1'b0; b_redirect_valid = 1'b0; b_redirect_pc = 32'h0;
      mem_ready_cfg = 1'b0; mem_k = 0; pend = 1'b0; cnt = 0; paddr = 32'h0; stray_ok = 1'b0;
      @(negedge clk);
      test_reset();
      test_stream();
      test_hold();
      test_redirect_wait();
      test_redirect_rsp();
      test_redirect_hold();
      test_wrap_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
